// File: rtl/inter_packet_gap_monitor.sv
// RX-side gap monitor: stamps the SOP-to-SOP arrival gap into first-beat tuser
// and keeps min/max/last gap plus packet-count statistics behind a 1-cycle skid buffer.
`timescale 1ns/1ps
module inter_packet_gap_monitor #(
    parameter int C_M_AXIS_DATA_WIDTH   = 256,
    parameter int C_S_AXIS_DATA_WIDTH   = 256,
    parameter int C_M_AXIS_TUSER_WIDTH  = 128,
    parameter int C_S_AXIS_TUSER_WIDTH  = 128,
    parameter int C_S_AXI_DATA_WIDTH    = 32,
    parameter int C_TUSER_TIMESTAMP_POS = 32
) (
    input  logic                                 axi_aclk,
    input  logic                                 axi_aresetn,
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_axis_tuser,
    input  logic                                 s_axis_tvalid,
    output logic                                 s_axis_tready,
    input  logic                                 s_axis_tlast,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]     m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    input  logic                                 sw_rst,
    input  logic                                 mon_en,
    input  logic                                 stats_clr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        pkt_count,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        last_gap,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        min_gap,
    output logic [C_S_AXI_DATA_WIDTH-1:0]        max_gap
);
    localparam int DW = C_S_AXIS_DATA_WIDTH;
    localparam int UW = C_S_AXIS_TUSER_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH;
    localparam int TP = C_TUSER_TIMESTAMP_POS;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [DW/8-1:0] strb;
        logic [UW-1:0]   user;
        logic            last;
    } beat_t;

    typedef enum logic {HEADER = 1'b0, BODY = 1'b1} state_t;

    state_t        state_q, state_d;
    logic          is_sop, in_hs, sop_hs, stamp;
    logic          tready_q, tready_d;
    logic [63:0]   timer_q, timer_d, last_sop_q, last_sop_d, dt;
    logic          first_q, first_d, first_eff;
    logic [31:0]   gap;
    logic [SW-1:0] cnt_q, cnt_d, last_q, last_d, min_q, min_d, max_q, max_d;
    beat_t         in_beat, out_q, out_d, skid_q, skid_d;
    logic          out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;

    assign in_hs  = s_axis_tvalid && tready_q;
    assign sop_hs = in_hs && is_sop;
    assign stamp  = sop_hs && mon_en;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state_q <= HEADER;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (in_hs) begin
            case (state_q)
                HEADER:  if (!s_axis_tlast) state_d = BODY;
                BODY:    if (s_axis_tlast)  state_d = HEADER;
                default: state_d = HEADER;
            endcase
        end
        if (sw_rst) state_d = HEADER;
    end

    always_comb begin
        is_sop = (state_q == HEADER);
    end

    // A clear in the same cycle as an SOP makes that SOP the first of the new epoch.
    assign first_eff = first_q || stats_clr;
    assign dt        = timer_q - last_sop_q;
    assign gap       = first_eff ? 32'd0 : ((|dt[63:32]) ? 32'hFFFF_FFFF : dt[31:0]);
    assign timer_d   = sw_rst ? 64'd0 : timer_q + 64'd1;

    always_comb begin
        in_beat.data = s_axis_tdata;
        in_beat.strb = s_axis_tstrb;
        in_beat.user = s_axis_tuser;
        in_beat.last = s_axis_tlast;
        if (stamp) in_beat.user[TP +: 32] = gap;
    end

    always_comb begin
        cnt_d      = stats_clr ? '0 : cnt_q;
        last_d     = stats_clr ? '0 : last_q;
        min_d      = stats_clr ? '1 : min_q;
        max_d      = stats_clr ? '0 : max_q;
        first_d    = first_eff;
        last_sop_d = last_sop_q;
        if (sop_hs) begin
            if (mon_en) begin
                first_d    = 1'b0;
                last_sop_d = timer_q;
                if (cnt_d != '1) cnt_d = cnt_d + SW'(1);
                if (!first_eff) begin
                    last_d = gap;
                    if (gap < min_d) min_d = gap;
                    if (gap > max_d) max_d = gap;
                end
            end else begin
                first_d = 1'b1;
            end
        end
        if (sw_rst) begin
            cnt_d = '0; last_d = '0; min_d = '1; max_d = '0;
            first_d = 1'b1; last_sop_d = '0;
        end
    end

    // Skid entry only fills when the output register is stalled; ready is its registered inverse.
    always_comb begin
        out_d      = out_q;
        out_vld_d  = out_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (!out_vld_q || m_axis_tready) begin
            if (skid_vld_q) begin
                out_d      = skid_q;
                out_vld_d  = 1'b1;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = in_hs;
                if (in_hs) out_d = in_beat;
            end
        end else if (in_hs) begin
            skid_d     = in_beat;
            skid_vld_d = 1'b1;
        end
        tready_d = !skid_vld_d;
        if (sw_rst) begin
            out_d = '0; out_vld_d = 1'b0; skid_d = '0; skid_vld_d = 1'b0; tready_d = 1'b0;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            timer_q    <= '0;
            last_sop_q <= '0;
            first_q    <= 1'b1;
            cnt_q      <= '0;
            last_q     <= '0;
            min_q      <= '1;
            max_q      <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            tready_q   <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            last_sop_q <= last_sop_d;
            first_q    <= first_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            min_q      <= min_d;
            max_q      <= max_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            tready_q   <= tready_d;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = out_q.data;
    assign m_axis_tstrb  = out_q.strb;
    assign m_axis_tuser  = out_q.user;
    assign m_axis_tlast  = out_q.last;
    assign m_axis_tvalid = out_vld_q;
    assign pkt_count     = cnt_q;
    assign last_gap      = last_q;
    assign min_gap       = min_q;
    assign max_gap       = max_q;
endmodule

// File: tb/tb_inter_packet_gap_monitor.sv
// Bench for inter_packet_gap_monitor: directed scenarios plus a randomized
// backpressure run, checked against a cycle-count based gap/statistics model.
`timescale 1ns/1ps
module tb_inter_packet_gap_monitor;
    localparam int DW = 256, UW = 128, SW = 32, TP = 32;

    typedef struct packed {
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic [UW-1:0]   u;
        logic            l;
    } beat_t;

    logic            axi_aclk = 1'b0, axi_aresetn = 1'b0;
    logic [DW-1:0]   s_axis_tdata = '0;
    logic [DW/8-1:0] s_axis_tstrb = '0;
    logic [UW-1:0]   s_axis_tuser = '0;
    logic            s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [DW/8-1:0] m_axis_tstrb;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tvalid, m_axis_tlast, m_axis_tready = 1'b1;
    logic            sw_rst = 1'b0, mon_en = 1'b1, stats_clr = 1'b0;
    logic [SW-1:0]   pkt_count, last_gap, min_gap, max_gap;

    always #5 axi_aclk = ~axi_aclk;

    inter_packet_gap_monitor dut (
        .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .sw_rst(sw_rst), .mon_en(mon_en), .stats_clr(stats_clr),
        .pkt_count(pkt_count), .last_gap(last_gap), .min_gap(min_gap), .max_gap(max_gap)
    );

    int          errors = 0, checks = 0;
    logic        rand_rdy = 1'b0;
    logic [63:0] tim_ofs = '0, force_v = '0;

    // Reference model: gap = difference of acceptance cycle numbers; outputs recorded in arrival order.
    logic [63:0] m_cyc, m_lsop, m_now, m_dt;
    logic        m_first, m_inpkt;
    logic [31:0] m_cnt, m_last, m_min, m_max, m_gap;
    beat_t       m_b;
    beat_t       exp_arr [2048];
    beat_t       obs_arr [2048];
    int          n_in = 0, n_out = 0;

    initial forever begin
        @(posedge axi_aclk or negedge axi_aresetn);
        if (!axi_aresetn || sw_rst) begin
            m_cyc = 0; m_lsop = 0; m_first = 1; m_inpkt = 0;
            m_cnt = 0; m_last = 0; m_min = '1; m_max = 0;
            n_in = n_out;
        end else begin
            if (m_axis_tvalid && m_axis_tready) begin
                if (n_out < 2048) obs_arr[n_out] = {m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast};
                n_out++;
            end
            if (stats_clr) begin
                m_cnt = 0; m_last = 0; m_min = '1; m_max = 0; m_first = 1;
            end
            if (s_axis_tvalid && s_axis_tready) begin
                m_b = {s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tlast};
                if (!m_inpkt) begin
                    if (mon_en) begin
                        m_now = m_cyc + tim_ofs;
                        m_dt  = m_now - m_lsop;
                        m_gap = (m_dt > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : m_dt[31:0];
                        if (m_first) m_gap = 0;
                        else begin
                            m_last = m_gap;
                            if (m_gap < m_min) m_min = m_gap;
                            if (m_gap > m_max) m_max = m_gap;
                        end
                        m_first = 0;
                        m_lsop  = m_now;
                        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                        m_b.u[TP +: 32] = m_gap;
                    end else begin
                        m_first = 1;
                    end
                end
                m_inpkt = !s_axis_tlast;
                if (n_in < 2048) exp_arr[n_in] = m_b;
                n_in++;
            end
            m_cyc++;
        end
    end

    task automatic cycle();
        @(posedge axi_aclk);
        #1;
        if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        s_axis_tvalid = 1'b0;
        repeat (n) cycle();
    endtask

    task automatic send_beat(input logic last);
        bit acc;
        int n;
        for (int k = 0; k < DW / 32; k++) s_axis_tdata[k*32 +: 32] = $urandom;
        for (int k = 0; k < UW / 32; k++) s_axis_tuser[k*32 +: 32] = $urandom;
        s_axis_tstrb  = $urandom;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        n = 0;
        do begin
            acc = s_axis_tready;
            cycle();
            n++;
        end while (!acc && n < 500);
        checks++;
        if (!acc) begin errors++; $display("FAIL accept_timeout got=no-handshake exp=handshake within 500 cycles"); end
    endtask

    task automatic test_reset();
        axi_aresetn = 1'b0;
        #23;
        checks += 8;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got=%0b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== '0)    begin errors++; $display("FAIL rst_mdata got=%h exp=0", m_axis_tdata); end
        if (m_axis_tuser !== '0)    begin errors++; $display("FAIL rst_muser got=%h exp=0", m_axis_tuser); end
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%0b exp=0", s_axis_tready); end
        if (pkt_count !== 32'd0)    begin errors++; $display("FAIL rst_cnt got=%h exp=0", pkt_count); end
        if (last_gap !== 32'd0)     begin errors++; $display("FAIL rst_last got=%h exp=0", last_gap); end
        if (max_gap !== 32'd0)      begin errors++; $display("FAIL rst_max got=%h exp=0", max_gap); end
        if (min_gap !== 32'hFFFF_FFFF) begin errors++; $display("FAIL rst_min got=%h exp=ffffffff", min_gap); end
        axi_aresetn = 1'b1;
        #1;
        checks++;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL rel_tready_early got=%0b exp=0", s_axis_tready); end
        cycle();
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rel_tready got=%0b exp=1", s_axis_tready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] eg;
        for (int i = 0; i < 3; i++) begin
            send_beat(1'b1);
            eg = (i == 0) ? 32'd0 : 32'd1;
            checks++;
            if (!m_axis_tvalid || m_axis_tuser[TP +: 32] !== eg)
                begin errors++; $display("FAIL b2b_gap%0d got=%h/v%0b exp=%h", i, m_axis_tuser[TP +: 32], m_axis_tvalid, eg); end
        end
        idle(1);
        checks += 4;
        if (pkt_count !== 32'd3) begin errors++; $display("FAIL b2b_cnt got=%0d exp=3", pkt_count); end
        if (min_gap !== 32'd1)   begin errors++; $display("FAIL b2b_min got=%0d exp=1", min_gap); end
        if (max_gap !== 32'd1)   begin errors++; $display("FAIL b2b_max got=%0d exp=1", max_gap); end
        if (last_gap !== 32'd1)  begin errors++; $display("FAIL b2b_last got=%0d exp=1", last_gap); end
    endtask

    task automatic test_sop_spacing();
        int          spacing [2] = '{10, 25};
        logic [31:0] eg [3] = '{32'd0, 32'd10, 32'd25};
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 4; b++) begin
                send_beat(b == 3);
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== s_axis_tdata || m_axis_tlast !== s_axis_tlast)
                    begin errors++; $display("FAIL lat_p%0d_b%0d got=v%0b %h exp=v1 %h", p, b, m_axis_tvalid, m_axis_tdata[31:0], s_axis_tdata[31:0]); end
                if (b == 0) begin
                    checks++;
                    if (m_axis_tuser[TP +: 32] !== eg[p])
                        begin errors++; $display("FAIL spacing_gap%0d got=%0d exp=%0d", p, m_axis_tuser[TP +: 32], eg[p]); end
                end
            end
            if (p < 2) idle(spacing[p] - 4);
        end
        idle(1);
        checks += 4;
        if (pkt_count !== 32'd3) begin errors++; $display("FAIL spacing_cnt got=%0d exp=3", pkt_count); end
        if (min_gap !== 32'd10)  begin errors++; $display("FAIL spacing_min got=%0d exp=10", min_gap); end
        if (max_gap !== 32'd25)  begin errors++; $display("FAIL spacing_max got=%0d exp=25", max_gap); end
        if (last_gap !== 32'd25) begin errors++; $display("FAIL spacing_last got=%0d exp=25", last_gap); end
    endtask

    task automatic test_sw_rst();
        sw_rst = 1'b1;
        cycle();
        sw_rst = 1'b0;
        checks += 5;
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL swrst_tready got=%0b exp=0", s_axis_tready); end
        if (m_axis_tdata !== '0)    begin errors++; $display("FAIL swrst_mdata got=%h exp=0", m_axis_tdata[31:0]); end
        if (pkt_count !== 32'd0)    begin errors++; $display("FAIL swrst_cnt got=%0d exp=0", pkt_count); end
        if (min_gap !== 32'hFFFF_FFFF) begin errors++; $display("FAIL swrst_min got=%h exp=ffffffff", min_gap); end
        if (max_gap !== 32'd0)      begin errors++; $display("FAIL swrst_max got=%h exp=0", max_gap); end
        cycle();
        checks++;
        if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL swrst_tready_rise got=%0b exp=1", s_axis_tready); end
    endtask

    task automatic test_random_backpressure();
        int n;
        rand_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) send_beat(b == n - 1);
            idle($urandom_range(0, 2));
        end
        rand_rdy = 1'b0;
        m_axis_tready = 1'b1;
        n = 0;
        while (n_out != n_in && n < 50) begin cycle(); n++; end
        checks += 4;
        if (n_out != n_in)      begin errors++; $display("FAIL rand_drain got=%0d out exp=%0d in", n_out, n_in); end
        if (pkt_count !== m_cnt) begin errors++; $display("FAIL rand_cnt got=%0d exp=%0d", pkt_count, m_cnt); end
        if (min_gap !== m_min)   begin errors++; $display("FAIL rand_min got=%0d exp=%0d", min_gap, m_min); end
        if (max_gap !== m_max)   begin errors++; $display("FAIL rand_max got=%0d exp=%0d", max_gap, m_max); end
    endtask

    task automatic test_mon_en();
        logic [31:0] c0, l0;
        c0 = m_cnt;
        l0 = m_last;
        mon_en = 1'b0;
        for (int p = 0; p < 3; p++) begin send_beat(1'b0); send_beat(1'b1); idle(p); end
        idle(1);
        checks += 2;
        if (pkt_count !== c0) begin errors++; $display("FAIL monoff_cnt got=%0d exp=%0d", pkt_count, c0); end
        if (last_gap !== l0)  begin errors++; $display("FAIL monoff_last got=%0d exp=%0d", last_gap, l0); end
        mon_en = 1'b1;
        send_beat(1'b1);
        checks++;
        if (!m_axis_tvalid || m_axis_tuser[TP +: 32] !== 32'd0)
            begin errors++; $display("FAIL reen_gap got=%h exp=0", m_axis_tuser[TP +: 32]); end
        idle(3);
        send_beat(1'b1);
        idle(1);
        checks += 2;
        if (last_gap !== 32'd4)      begin errors++; $display("FAIL reen_last got=%0d exp=4", last_gap); end
        if (pkt_count !== c0 + 2)    begin errors++; $display("FAIL reen_cnt got=%0d exp=%0d", pkt_count, c0 + 2); end
    endtask

    task automatic test_clr_with_sop();
        idle(2);
        stats_clr = 1'b1;
        send_beat(1'b1);
        stats_clr = 1'b0;
        checks += 5;
        if (m_axis_tuser[TP +: 32] !== 32'd0) begin errors++; $display("FAIL clr_gap got=%h exp=0", m_axis_tuser[TP +: 32]); end
        if (pkt_count !== 32'd1)       begin errors++; $display("FAIL clr_cnt got=%0d exp=1", pkt_count); end
        if (min_gap !== 32'hFFFF_FFFF) begin errors++; $display("FAIL clr_min got=%h exp=ffffffff", min_gap); end
        if (max_gap !== 32'd0)         begin errors++; $display("FAIL clr_max got=%h exp=0", max_gap); end
        if (last_gap !== 32'd0)        begin errors++; $display("FAIL clr_last got=%h exp=0", last_gap); end
    endtask

    task automatic test_gap_saturation();
        idle(2);
        force_v = m_lsop + 64'h1_0000_0005;
        tim_ofs = force_v - m_cyc;
        force dut.timer_q = force_v;
        send_beat(1'b1);
        release dut.timer_q;
        checks += 3;
        if (m_axis_tuser[TP +: 32] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_gap got=%h exp=ffffffff", m_axis_tuser[TP +: 32]); end
        if (max_gap !== 32'hFFFF_FFFF)  begin errors++; $display("FAIL sat_max got=%h exp=ffffffff", max_gap); end
        if (last_gap !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_last got=%h exp=ffffffff", last_gap); end
        idle(1);
        stats_clr = 1'b1;
        cycle();
        stats_clr = 1'b0;
    endtask

    task automatic test_async_reset();
        send_beat(1'b0);
        send_beat(1'b0);
        #3;
        axi_aresetn = 1'b0;
        tim_ofs = '0;
        #1;
        checks += 5;
        if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL arst_mvalid got=%0b exp=0", m_axis_tvalid); end
        if (m_axis_tdata !== '0)    begin errors++; $display("FAIL arst_mdata got=%h exp=0", m_axis_tdata[31:0]); end
        if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL arst_tready got=%0b exp=0", s_axis_tready); end
        if (pkt_count !== 32'd0)    begin errors++; $display("FAIL arst_cnt got=%0d exp=0", pkt_count); end
        if (min_gap !== 32'hFFFF_FFFF) begin errors++; $display("FAIL arst_min got=%h exp=ffffffff", min_gap); end
        #12;
        axi_aresetn = 1'b1;
        send_beat(1'b0);
        checks += 2;
        if (!m_axis_tvalid || m_axis_tuser[TP +: 32] !== 32'd0)
            begin errors++; $display("FAIL arst_sop_gap got=%h exp=0", m_axis_tuser[TP +: 32]); end
        if (pkt_count !== 32'd1) begin errors++; $display("FAIL arst_sop_cnt got=%0d exp=1", pkt_count); end
        send_beat(1'b1);
        send_beat(1'b1);
        idle(1);
        checks += 2;
        if (last_gap !== 32'd2)  begin errors++; $display("FAIL arst_next_gap got=%0d exp=2", last_gap); end
        if (pkt_count !== 32'd2) begin errors++; $display("FAIL arst_next_cnt got=%0d exp=2", pkt_count); end
    endtask

    task automatic test_stream_integrity();
        idle(4);
        checks++;
        if (n_out != n_in) begin errors++; $display("FAIL stream_count got=%0d out exp=%0d in", n_out, n_in); end
        for (int i = 0; i < n_out && i < 2048; i++) begin
            checks++;
            if (obs_arr[i] !== exp_arr[i])
                begin errors++; $display("FAIL stream_beat%0d got=user %h last %0b exp=user %h last %0b", i, obs_arr[i].u, obs_arr[i].l, exp_arr[i].u, exp_arr[i].l); end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_sop_spacing();
        test_sw_rst();
        test_random_backpressure();
        test_mon_en();
        test_clr_with_sop();
        test_gap_saturation();
        test_async_reset();
        test_stream_integrity();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
